// File: rtl/pipe_regfile.sv
// ============================================================================
// Module     : pipe_regfile
// Description: Two-write, two-read register file with a per-register busy
//              scoreboard for decode-stage hazard detection.
//              Optional macro PIPE_REGFILE_BYPASS_EN enables same-cycle
//              write-to-read forwarding of data and busy release.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wen0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              wen1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [ADDR_W-1:0] raddr0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy0,
  output logic              busy1,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              flush
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_next;
  logic              wr0_ok;
  logic              wr1_ok;

  assign wr0_ok = wen0 && !((ZERO_REG != 0) && (waddr0 == '0));
  assign wr1_ok = wen1 && !((ZERO_REG != 0) && (waddr1 == '0));

  // Flush first, then releases, then reserve so a new producer always wins.
  always_comb begin
    busy_next = busy_q;
    if (flush) busy_next = '0;
    if (wen0) busy_next[waddr0] = 1'b0;
    if (wen1) busy_next[waddr1] = 1'b0;
    if (rsv_en) busy_next[rsv_addr] = 1'b1;
    if (ZERO_REG != 0) busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy_q <= '0;
    end else begin
      if (wr0_ok) regs[waddr0] <= wdata0;
      if (wr1_ok) regs[waddr1] <= wdata1;
      busy_q <= busy_next;
    end
  end

  logic [ADDR_W-1:0] raddr_a [2];
  logic [DATA_W-1:0] rdata_a [2];
  logic              busy_a  [2];

  assign raddr_a[0] = raddr0;
  assign raddr_a[1] = raddr1;
  assign rdata0     = rdata_a[0];
  assign rdata1     = rdata_a[1];
  assign busy0      = busy_a[0];
  assign busy1      = busy_a[1];

  for (genvar p = 0; p < 2; p++) begin : g_rd
    always_comb begin
      rdata_a[p] = regs[raddr_a[p]];
      busy_a[p]  = busy_q[raddr_a[p]];
`ifdef PIPE_REGFILE_BYPASS_EN
      // Port 1 is checked last so it takes priority, matching the array.
      if (wen0 && (waddr0 == raddr_a[p])) begin
        rdata_a[p] = wdata0;
        busy_a[p]  = rsv_en && (rsv_addr == raddr_a[p]);
      end
      if (wen1 && (waddr1 == raddr_a[p])) begin
        rdata_a[p] = wdata1;
        busy_a[p]  = rsv_en && (rsv_addr == raddr_a[p]);
      end
`endif
      if ((ZERO_REG != 0) && (raddr_a[p] == '0)) begin
        rdata_a[p] = '0;
        busy_a[p]  = 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipe_regfile.sv
// ============================================================================
// Module     : tb_pipe_regfile
// Description: Directed self-checking bench for pipe_regfile (default params).
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        wen0, wen1, rsv_en, flush;
  logic [4:0]  waddr0, waddr1, raddr0, raddr1, rsv_addr;
  logic [31:0] wdata0, wdata1, rdata0, rdata1;
  logic        busy0, busy1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_regfile dut (
    .clk(clk), .rst(rst),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr0(raddr0), .raddr1(raddr1),
    .rdata0(rdata0), .rdata1(rdata1),
    .busy0(busy0), .busy1(busy1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush)
  );

  typedef struct {
    logic        wen0;  logic [4:0] waddr0; logic [31:0] wdata0;
    logic        wen1;  logic [4:0] waddr1; logic [31:0] wdata1;
    logic        rsv_en; logic [4:0] rsv_addr; logic flush;
    logic [4:0]  raddr0; logic [31:0] exp_rd0; logic exp_bz0;
    logic [4:0]  raddr1; logic [31:0] exp_rd1; logic exp_bz1;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    wen0 = 0; wen1 = 0; rsv_en = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; idle();
    waddr0 = 0; waddr1 = 0; wdata0 = 0; wdata1 = 0;
    raddr0 = 0; raddr1 = 0; rsv_addr = 0;

    // Each vector: controls held for one edge, then reads checked with controls off.
    vecs[0]  = '{1,7,32'h11,        1,7,32'h22,   0,0,0,  7,32'h22,0,   0,32'h0,0};
    vecs[1]  = '{1,0,32'hFFFFFFFF,  0,0,0,        1,0,0,  0,32'h0,0,    7,32'h22,0};
    vecs[2]  = '{0,0,0,             0,0,0,        1,5,0,  5,32'h0,1,    0,32'h0,0};
    vecs[3]  = '{1,5,32'h1234,      0,0,0,        1,5,0,  5,32'h1234,1, 7,32'h22,0};
    vecs[4]  = '{0,0,0,             1,5,32'h5678, 0,0,0,  5,32'h5678,0, 7,32'h22,0};
    vecs[5]  = '{0,0,0,             0,0,0,        1,3,0,  3,32'h0,1,    5,32'h5678,0};
    vecs[6]  = '{0,0,0,             0,0,0,        1,9,0,  9,32'h0,1,    3,32'h0,1};
    vecs[7]  = '{1,3,32'hABC,       0,0,0,        1,12,1, 3,32'hABC,0,  12,32'h0,1};
    vecs[8]  = '{0,0,0,             0,0,0,        0,0,0,  9,32'h0,0,    12,32'h0,1};
    vecs[9]  = '{1,12,32'h1,        1,9,32'h2,    0,0,0,  12,32'h1,0,   9,32'h2,0};
    vecs[10] = '{1,20,32'h33,       1,21,32'h44,  1,20,0, 20,32'h33,1,  21,32'h44,0};
    vecs[11] = '{0,0,0,             0,0,0,        0,0,1,  20,32'h33,0,  21,32'h44,0};

    tick(); tick();
    rst = 0;

    // Fill every register, then confirm state exists before reset.
    for (int i = 0; i < 16; i++) begin
      wen0 = 1; waddr0 = 5'(2*i);   wdata0 = 32'hA5A5A5A5;
      wen1 = 1; waddr1 = 5'(2*i+1); wdata1 = 32'hA5A5A5A5;
      tick();
    end
    idle();
    rsv_en = 1; rsv_addr = 6;
    tick(); idle();
    raddr0 = 5; raddr1 = 6; #1;
    chk("prefill_r5", rdata0, 32'hA5A5A5A5);
    chk("prefill_busy6", {31'b0, busy1}, 32'h1);

    // Reset with a write and reserve in the same cycle: both discarded.
    rst = 1; wen0 = 1; waddr0 = 10; wdata0 = 32'h77; rsv_en = 1; rsv_addr = 10;
    tick(); idle(); rst = 0;
    for (int a = 0; a < 32; a += 2) begin
      raddr0 = 5'(a); raddr1 = 5'(a + 1); #1;
      chk($sformatf("rst_rd_r%0d", a),     rdata0, 32'h0);
      chk($sformatf("rst_rd_r%0d", a + 1), rdata1, 32'h0);
      chk($sformatf("rst_bz_r%0d", a),     {31'b0, busy0}, 32'h0);
      chk($sformatf("rst_bz_r%0d", a + 1), {31'b0, busy1}, 32'h0);
    end

    for (int v = 0; v < 12; v++) begin
      wen0 = vecs[v].wen0; waddr0 = vecs[v].waddr0; wdata0 = vecs[v].wdata0;
      wen1 = vecs[v].wen1; waddr1 = vecs[v].waddr1; wdata1 = vecs[v].wdata1;
      rsv_en = vecs[v].rsv_en; rsv_addr = vecs[v].rsv_addr; flush = vecs[v].flush;
      raddr0 = vecs[v].raddr0; raddr1 = vecs[v].raddr1;
      tick(); idle(); #1;
      chk($sformatf("vec%0d_rd0", v), rdata0, vecs[v].exp_rd0);
      chk($sformatf("vec%0d_bz0", v), {31'b0, busy0}, {31'b0, vecs[v].exp_bz0});
      chk($sformatf("vec%0d_rd1", v), rdata1, vecs[v].exp_rd1);
      chk($sformatf("vec%0d_bz1", v), {31'b0, busy1}, {31'b0, vecs[v].exp_bz1});
    end

    // Same-cycle write/read on r4, with r4 reserved beforehand.
    rsv_en = 1; rsv_addr = 4;
    tick(); idle();
    raddr0 = 4; wen0 = 1; waddr0 = 4; wdata0 = 32'hCAFE; #1;
`ifdef PIPE_REGFILE_BYPASS_EN
    chk("bypass_rd", rdata0, 32'hCAFE);
    chk("bypass_bz", {31'b0, busy0}, 32'h0);
`else
    chk("nobypass_rd", rdata0, 32'h0);
    chk("nobypass_bz", {31'b0, busy0}, 32'h1);
`endif
    tick(); idle(); #1;
    chk("after_wr_rd", rdata0, 32'hCAFE);
    chk("after_wr_bz", {31'b0, busy0}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
